// File: rtl/rotary_quad_decoder_if.sv
// Encoder pin and detent-event bundle shared by the rotary decoder and its consumers.
// master drives the raw pins (panel/bench side); slave is the decoder.
interface rotary_quad_decoder_if #(
  parameter int POS_W = 3
);
  logic             rot_a;
  logic             rot_b;
  logic             rot_event;
  logic             rot_right;
  logic [POS_W-1:0] pos;
  logic             at_limit;
  logic             quad_err;

  modport master (
    output rot_a, rot_b,
    input  rot_event, rot_right, pos, at_limit, quad_err
  );

  modport slave (
    input  rot_a, rot_b,
    output rot_event, rot_right, pos, at_limit, quad_err
  );
endinterface

// File: rtl/rotary_quad_decoder.sv
// Rotary encoder front end: sync + debounce of A/B, quadrature decode, detent events, position index.
// Build option ROT_WRAP_EN: pos wraps between POS_MIN and POS_MAX instead of saturating.
module rotary_quad_decoder #(
  parameter int FILTER_CYCLES    = 1000,
  parameter int STEPS_PER_DETENT = 4,
  parameter int POS_W            = 3,
  parameter int POS_MIN          = 0,
  parameter int POS_MAX          = 4,
  parameter int POS_RESET        = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  rotary_quad_decoder_if.slave   bus
);

  localparam int FCW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam int SW  = $clog2(STEPS_PER_DETENT) + 2;

  localparam logic [FCW-1:0]        FLT_LAST = FCW'(FILTER_CYCLES - 1);
  localparam logic signed [SW-1:0]  STEP_ONE = SW'(1);
  localparam logic signed [SW-1:0]  STEP_POS = SW'(STEPS_PER_DETENT);
  localparam logic signed [SW-1:0]  STEP_NEG = -STEP_POS;

  localparam logic [POS_W-1:0] POS_MIN_C   = POS_W'(POS_MIN);
  localparam logic [POS_W-1:0] POS_MAX_C   = POS_W'(POS_MAX);
  localparam logic [POS_W-1:0] POS_RESET_C = POS_W'(POS_RESET);
  localparam logic [POS_W-1:0] POS_ONE     = POS_W'(1);

`ifdef ROT_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  // Channel vectors are {A, B}: bit 1 = A, bit 0 = B.
  logic [1:0]          sync1_q, sync1_d;
  logic [1:0]          sync2_q, sync2_d;
  logic [1:0]          sync_prev_q, sync_prev_d;
  logic [1:0][FCW-1:0] flt_cnt_q, flt_cnt_d;
  logic [1:0]          filt_q, filt_d;
  logic [1:0]          filt_prev_q, filt_prev_d;
  logic signed [SW-1:0] sub_q, sub_d;
  logic                event_q, event_d;
  logic                right_q, right_d;
  logic                err_q, err_d;
  logic [POS_W-1:0]    pos_q, pos_d;

  logic [1:0]           phase_diff;
  logic signed [SW-1:0] delta;
  logic signed [SW-1:0] sub_sum;
  logic                 illegal;

  // Position of a state around the quadrature cycle 11 -> 01 -> 00 -> 10.
  function automatic logic [1:0] gray_idx(input logic [1:0] ab);
    case (ab)
      2'b11:   return 2'd0;
      2'b01:   return 2'd1;
      2'b00:   return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    sync1_d     = {bus.rot_a, bus.rot_b};
    sync2_d     = sync1_q;
    sync_prev_d = sync2_q;
    filt_d      = filt_q;
    flt_cnt_d   = '0;
    filt_prev_d = filt_q;
    delta       = '0;
    illegal     = 1'b0;
    sub_d       = sub_q;
    event_d     = 1'b0;
    right_d     = right_q;
    err_d       = 1'b0;
    pos_d       = pos_q;

    // A fresh change restarts the stability count, so glitches never accumulate.
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != sync_prev_q[i] || sync2_q[i] == filt_q[i]) begin
        flt_cnt_d[i] = '0;
      end else if (flt_cnt_q[i] == FLT_LAST) begin
        filt_d[i] = sync2_q[i];
      end else begin
        flt_cnt_d[i] = flt_cnt_q[i] + FCW'(1);
      end
    end

    phase_diff = gray_idx(filt_q) - gray_idx(filt_prev_q);
    case (phase_diff)
      2'd1:    delta = STEP_ONE;
      2'd3:    delta = -STEP_ONE;
      2'd2:    illegal = 1'b1;
      default: delta = '0;
    endcase
    sub_sum = sub_q + delta;

    if (illegal) begin
      err_d = 1'b1;
      sub_d = '0;
    end else if (delta != '0) begin
      if (sub_sum == STEP_POS || sub_sum == STEP_NEG) begin
        event_d = 1'b1;
        right_d = (sub_sum == STEP_POS);
        sub_d   = '0;
        if (right_d) begin
          pos_d = (pos_q == POS_MAX_C) ? (WRAP ? POS_MIN_C : pos_q) : pos_q + POS_ONE;
        end else begin
          pos_d = (pos_q == POS_MIN_C) ? (WRAP ? POS_MAX_C : pos_q) : pos_q - POS_ONE;
        end
      end else begin
        sub_d = sub_sum;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= 2'b11;
      sync2_q     <= 2'b11;
      sync_prev_q <= 2'b11;
      flt_cnt_q   <= '0;
      filt_q      <= 2'b11;
      filt_prev_q <= 2'b11;
      sub_q       <= '0;
      event_q     <= 1'b0;
      right_q     <= 1'b0;
      err_q       <= 1'b0;
      pos_q       <= POS_RESET_C;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      sync_prev_q <= sync_prev_d;
      flt_cnt_q   <= flt_cnt_d;
      filt_q      <= filt_d;
      filt_prev_q <= filt_prev_d;
      sub_q       <= sub_d;
      event_q     <= event_d;
      right_q     <= right_d;
      err_q       <= err_d;
      pos_q       <= pos_d;
    end
  end

  assign bus.rot_event = event_q;
  assign bus.rot_right = right_q;
  assign bus.quad_err  = err_q;
  assign bus.pos       = pos_q;
  assign bus.at_limit  = (pos_q == POS_MIN_C) || (pos_q == POS_MAX_C);

endmodule

// File: tb/tb_rotary_quad_decoder.sv
// Scoreboard bench for rotary_quad_decoder: expected detent events are queued as the
// pins are driven and popped by a monitor whenever rot_event pulses.
module tb_rotary_quad_decoder;

  localparam int FC   = 4;
  localparam int SPD  = 4;
  localparam int PW   = 3;
  localparam int PMIN = 0;
  localparam int PMAX = 4;
  localparam int PRST = 2;
  localparam int HOLD = 10;

`ifdef ROT_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  typedef struct packed {
    logic          right;
    logic [PW-1:0] pos;
    logic          at_limit;
  } ev_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  rotary_quad_decoder_if #(.POS_W(PW)) bus ();

  rotary_quad_decoder #(
    .FILTER_CYCLES    (FC),
    .STEPS_PER_DETENT (SPD),
    .POS_W            (PW),
    .POS_MIN          (PMIN),
    .POS_MAX          (PMAX),
    .POS_RESET        (PRST)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   errors     = 0;
  int   checks     = 0;
  int   err_pulses = 0;
  int   model_pos  = PRST;
  ev_t  sb_q[$];

  // Monitor: pops the scoreboard on each event, counts quad_err pulses, checks pulse widths.
  initial begin
    logic prev_ev;
    logic prev_err;
    ev_t  got;
    ev_t  exp;
    prev_ev  = 1'b0;
    prev_err = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_ev  = 1'b0;
        prev_err = 1'b0;
      end else begin
        if (bus.rot_event === 1'b1) begin
          checks++;
          if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: rot_event=1 right=%0b pos=%0d, required no event", bus.rot_right, bus.pos);
          end else begin
            exp = sb_q.pop_front();
            got = {bus.rot_right, bus.pos, bus.at_limit};
            if (got !== exp) begin
              errors++;
              $display("FAIL event_fields: got right=%0b pos=%0d at_limit=%0b, required right=%0b pos=%0d at_limit=%0b",
                       got.right, got.pos, got.at_limit, exp.right, exp.pos, exp.at_limit);
            end
          end
          checks++;
          if (prev_ev) begin
            errors++;
            $display("FAIL event_width: rot_event high on 2 consecutive cycles, required 1");
          end
        end
        if (bus.quad_err === 1'b1) begin
          err_pulses++;
          checks++;
          if (prev_err) begin
            errors++;
            $display("FAIL quad_err_width: quad_err high on 2 consecutive cycles, required 1");
          end
        end
        prev_ev  = bus.rot_event;
        prev_err = bus.quad_err;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic int next_pos(input int p, input logic right);
    if (right) return (p == PMAX) ? (WRAP ? PMIN : PMAX) : p + 1;
    else       return (p == PMIN) ? (WRAP ? PMAX : PMIN) : p - 1;
  endfunction

  task automatic push_ev(input logic right);
    ev_t e;
    model_pos  = next_pos(model_pos, right);
    e.right    = right;
    e.pos      = PW'(model_pos);
    e.at_limit = (model_pos == PMIN) || (model_pos == PMAX);
    sb_q.push_back(e);
  endtask

  task automatic set_pins(input logic [1:0] ab, input int hold);
    @(negedge clk);
    bus.rot_a = ab[1];
    bus.rot_b = ab[0];
    repeat (hold) @(posedge clk);
  endtask

  task automatic detent_cw();
    set_pins(2'b01, HOLD);
    set_pins(2'b00, HOLD);
    set_pins(2'b10, HOLD);
    set_pins(2'b11, HOLD);
  endtask

  task automatic detent_ccw();
    set_pins(2'b10, HOLD);
    set_pins(2'b00, HOLD);
    set_pins(2'b01, HOLD);
    set_pins(2'b11, HOLD);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    bus.rot_a = 1'b1;
    bus.rot_b = 1'b1;
    repeat (FC + 4) @(posedge clk);
    @(negedge clk);
    reset     = 1'b0;
    model_pos = PRST;
    sb_q.delete();
  endtask

  task automatic check_state(input string name);
    logic exp_lim;
    @(negedge clk);
    exp_lim = (model_pos == PMIN) || (model_pos == PMAX);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_events: got %0d outstanding, required 0", name, sb_q.size());
    end
    checks++;
    if (bus.pos !== PW'(model_pos)) begin
      errors++;
      $display("FAIL %s_pos: got %0d, required %0d", name, bus.pos, model_pos);
    end
    checks++;
    if (bus.at_limit !== exp_lim) begin
      errors++;
      $display("FAIL %s_at_limit: got %0b, required %0b", name, bus.at_limit, exp_lim);
    end
  endtask

  task automatic check_err(input string name, input int base, input int exp_delta);
    checks++;
    if (err_pulses - base !== exp_delta) begin
      errors++;
      $display("FAIL %s_quad_err_count: got %0d, required %0d", name, err_pulses - base, exp_delta);
    end
  endtask

  task automatic check_sub(input string name, input int exp);
    int s;
    @(negedge clk);
    s = $signed(dut.sub_q);
    checks++;
    if (s !== exp) begin
      errors++;
      $display("FAIL %s_sub_step: got %0d, required %0d", name, s, exp);
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if (bus.rot_event !== 1'b0 || bus.rot_right !== 1'b0 || bus.quad_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got event=%0b right=%0b err=%0b, required 0 0 0",
               bus.rot_event, bus.rot_right, bus.quad_err);
    end
    check_state("reset");
  endtask

  task automatic test_cw_latency();
    int base;
    int first;
    base = err_pulses;
    push_ev(1'b1);
    set_pins(2'b01, HOLD);
    set_pins(2'b00, HOLD);
    set_pins(2'b10, HOLD);
    @(negedge clk);
    bus.rot_a = 1'b1;
    bus.rot_b = 1'b1;
    @(posedge clk);  // first edge that samples the new level
    first = -1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (bus.rot_event === 1'b1 && first < 0) first = k;
    end
    checks++;
    if (first !== 7) begin
      errors++;
      $display("FAIL cw_event_latency: got %0d cycles after first sampling edge, required 7", first);
    end
    check_state("cw");
    check_err("cw", base, 0);
  endtask

  task automatic test_ccw_to_limit();
    int base;
    do_reset();
    base = err_pulses;
    for (int i = 0; i < 3; i++) begin
      push_ev(1'b0);
      detent_ccw();
    end
    check_state("ccw");
    check_err("ccw", base, 0);
  endtask

  // A low pulse seen by n+1 sampling edges gives the filter n stable cycles after its change-detect cycle.
  task automatic run_glitch(input string name, input int n, input logic expect_change);
    logic a_low;
    int   sub_max;
    int   s;
    a_low   = 1'b0;
    sub_max = 0;
    for (int i = 0; i < n + 25; i++) begin
      @(negedge clk);
      if (i == 0)     bus.rot_a = 1'b0;
      if (i == n + 1) bus.rot_a = 1'b1;
      if (dut.filt_q[1] === 1'b0) a_low = 1'b1;
      s = $signed(dut.sub_q);
      if (s > sub_max) sub_max = s;
    end
    checks++;
    if (a_low !== expect_change) begin
      errors++;
      $display("FAIL %s_filtered_a_change: got %0b, required %0b", name, a_low, expect_change);
    end
    checks++;
    if (sub_max !== (expect_change ? 1 : 0)) begin
      errors++;
      $display("FAIL %s_sub_step_peak: got %0d, required %0d", name, sub_max, expect_change ? 1 : 0);
    end
  endtask

  task automatic test_glitch();
    int base;
    base = err_pulses;
    run_glitch("glitch3", 3, 1'b0);
    run_glitch("glitch4", 4, 1'b1);
    check_sub("glitch", 0);
    check_state("glitch");
    check_err("glitch", base, 0);
  endtask

  task automatic test_half_detent();
    set_pins(2'b01, HOLD);
    set_pins(2'b00, HOLD);
    check_sub("half_fwd", 2);
    set_pins(2'b01, HOLD);
    set_pins(2'b11, HOLD);
    check_sub("half_back", 0);
    check_state("half");
    push_ev(1'b1);
    detent_cw();
    check_state("half_then_cw");
  endtask

  task automatic test_illegal();
    int base;
    base = err_pulses;
    set_pins(2'b00, HOLD);
    check_err("illegal_first", base, 1);
    check_sub("illegal_first", 0);
    set_pins(2'b10, HOLD);
    set_pins(2'b11, HOLD);
    check_sub("illegal_pre", 2);
    set_pins(2'b00, HOLD);
    check_sub("illegal_clear", 0);
    set_pins(2'b10, HOLD);
    set_pins(2'b11, HOLD);
    set_pins(2'b10, HOLD);
    set_pins(2'b00, HOLD);
    set_pins(2'b11, HOLD);
    check_err("illegal_all", base, 3);
    check_sub("illegal_end", 0);
    check_state("illegal");
  endtask

  task automatic test_reset_mid_rotation();
    int base;
    set_pins(2'b01, HOLD);
    set_pins(2'b00, HOLD);
    do_reset();
    base = err_pulses;
    @(negedge clk);
    checks++;
    if (bus.rot_right !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_right: got %0b, required 0", bus.rot_right);
    end
    check_state("reset_mid");
    push_ev(1'b1);
    detent_cw();
    check_state("reset_mid_cw");
    check_err("reset_mid", base, 0);
  endtask

  task automatic test_pos_limit();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      push_ev(1'b1);
      detent_cw();
    end
    check_state("pos_limit");
  endtask

  initial begin
    bus.rot_a = 1'b1;
    bus.rot_b = 1'b1;
    test_reset();
    test_cw_latency();
    test_ccw_to_limit();
    test_glitch();
    test_half_detent();
    test_illegal();
    test_reset_mid_rotation();
    test_pos_limit();
    repeat (4) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rotary_quad_decoder.md
Name: rotary_quad_decoder

Overview:
Upstream input stage for the LED-dimmer/LCD demo. Conditions the raw quadrature pins of the panel rotary encoder. Emits one-cycle detent events with direction and a saturating position index. The PWM duty selector and LCD text logic consume `pos` and `rot_event` directly, so no further bookkeeping is needed downstream.

Parameters:
- FILTER_CYCLES, 1000: consecutive stable cycles required before a synced pin value is accepted (min 1).
- STEPS_PER_DETENT, 4: valid quadrature transitions per detent; legal values 1, 2, 4.
- POS_W, 3: width of `pos`.
- POS_MIN, 0: lower bound of `pos`.
- POS_MAX, 4: upper bound of `pos`.
- POS_RESET, 4: value of `pos` after reset; must lie within POS_MIN..POS_MAX.

Ports:
- clk  in  1  system clock
- reset  in  1  reset, synchronous, active-high; clock clk
- rot_a  in  1  raw encoder channel A, asynchronous
- rot_b  in  1  raw encoder channel B, asynchronous
- rot_event  out  1  one-cycle pulse per completed detent
- rot_right  out  1  direction of the most recent event (1 = clockwise); held between events
- pos  out  POS_W  detent position index
- at_limit  out  1  high when pos == POS_MIN or pos == POS_MAX
- quad_err  out  1  one-cycle pulse on an illegal two-bit quadrature jump

Behaviour:
- Reset values:
  - rot_event = 0, rot_right = 0, quad_err = 0, pos = POS_RESET.
  - Filtered A/B = 2'b11 (encoder idles high via pull-ups).
  - Sub-step counter = 0; filter counters = 0; synchronizer flops = 1.
- Synchronizer: a 2-flop synchronizer on each channel. Nothing downstream uses the raw pins.
- Filter (per channel, independent):
  - Counter increments while synced != filtered.
  - Counter clears to 0 when synced == filtered or when synced changed since the previous cycle.
  - When the counter equals FILTER_CYCLES-1 and synced != filtered: filtered <= synced and counter <= 0.
  - Glitches shorter than FILTER_CYCLES cycles never reach the decoder.
- Decoder: registers the previous filtered {A,B} and compares it with the current value each cycle.
  - Forward (+1): 11->01, 01->00, 00->10, 10->11.
  - Reverse (-1): 11->10, 10->00, 00->01, 01->11.
  - No change: no action.
  - Illegal jump (11<->00 or 01<->10, e.g. both filters completing in the same cycle): quad_err pulses, sub-step counter clears, pos unchanged.
- Sub-step counter: signed, range -STEPS_PER_DETENT..+STEPS_PER_DETENT.
  - On a step, add ±1.
  - A step opposite in sign to a nonzero count still just adds; this allows backing out of a half detent.
  - Reaching +STEPS_PER_DETENT: on the next edge, rot_event=1, rot_right=1, counter clears.
  - Reaching -STEPS_PER_DETENT: on the next edge, rot_event=1, rot_right=0, counter clears.
- Position:
  - pos updates on the same edge that raises rot_event: +1 if right, -1 otherwise.
  - pos saturates at POS_MAX / POS_MIN.
  - rot_event still pulses when saturated; pos does not change.
- at_limit: combinational from pos.
- Latency: a clean raw edge reaches filtered state 2+FILTER_CYCLES cycles after the first sampling edge. The completing step produces rot_event exactly 1 cycle after the filtered update.
- rot_event is never high for two consecutive cycles when FILTER_CYCLES ≥ 2.
- Reset mid-rotation: all partial progress is discarded. If the pins sit at a non-11 state after reset, the resulting first filtered change may be illegal; it is flagged via quad_err and otherwise ignored.

Optional Feature:
- Macro: ROT_WRAP_EN.
- Defined: pos wraps instead of saturating.
  - Increment from POS_MAX gives POS_MIN; decrement from POS_MIN gives POS_MAX.
  - at_limit stays as defined.
- Undefined: saturating behaviour as above.

Test Plan:
- Parameters for all scenarios: FILTER_CYCLES=4, STEPS_PER_DETENT=4, POS_RESET=2, POS_MIN=0, POS_MAX=4.
- Reset, then a full CW cycle 11->01->00->10->11, each state held 10 cycles -> one rot_event with rot_right=1, pos=3, quad_err never high; rot_event exactly 7 cycles after the raw 10->11 edge.
- Three full CCW detents -> three rot_event pulses with rot_right=0; pos 2->1->0->0; at_limit=1 from the second event on.
- Glitch: rot_a low for 3 cycles, then back high -> no filtered change, no rot_event, pos unchanged; repeat with 4 cycles -> filtered A changes, sub-step becomes +1, still no event.
- Half detent: 11->01->00 then 00->01->11 -> no rot_event, sub-step returns to 0, pos unchanged.
- Both pins 11->00 on the same cycle -> quad_err single pulse, no rot_event, sub-step cleared.
- Assert reset after 2 CW steps, then release -> pos=2, rot_right=0; a subsequent full CW detent yields exactly one event. With ROT_WRAP_EN, three CW detents from pos=2 give pos 3, 4, 0.
